mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin line-fill arbiter between L1I and L1D sharing one memory port.
// Optional stall watchdog enabled by defining ARB_TIMEOUT_EN.
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_I,
  input  logic [31:0] ADDR_I,
  input  logic        REQ_D,
  input  logic [31:0] ADDR_D,
  output logic        GNT_I,
  output logic        GNT_D,
  output logic        MEM_VALID,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_READY,
  input  logic [31:0] MEM_DATA,
  input  logic        MEM_WORD_VALID,
  input  logic [2:0]  MEM_WORD_IDX,
  output logic [31:0] FILL_DATA,
  output logic [2:0]  FILL_IDX,
  output logic        FILL_WE_I,
  output logic        FILL_WE_D,
  output logic        DONE_I,
  output logic        DONE_D,
  output logic        ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] LINE_MASK = ~(32'(WORDS_PER_LINE) - 32'd1);
  localparam logic [2:0]  LAST_IDX  = 3'(WORDS_PER_LINE - 1);
  localparam int          STALL_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  state_t             state_q;
  logic               last_d_q;   // 1: L1D was served last, 0: L1I
  logic [2:0]         cnt_q;
  logic [STALL_W-1:0] stall_q;
  logic               gnt_i_q, gnt_d_q, mem_valid_q;
  logic [31:0]        mem_addr_q, fill_data_q;
  logic [2:0]         fill_idx_q;
  logic               fill_we_i_q, fill_we_d_q, done_i_q, done_d_q, err_q;

  logic               w_accept, w_progress, w_timeout, w_pick_d;
  logic [STALL_W-1:0] w_stall_inc;

  assign w_accept    = (state_q == S_FILL) && MEM_WORD_VALID && (MEM_WORD_IDX == cnt_q);
  assign w_progress  = ((state_q == S_ADDR) && MEM_READY) || w_accept;
  assign w_timeout   = TO_EN && ((state_q == S_ADDR) || (state_q == S_FILL)) &&
                       !w_progress && (stall_q == STALL_LIMIT);
  assign w_pick_d    = REQ_D && (!REQ_I || !last_d_q);
  // Without the watchdog the counter never leaves zero and folds away.
  assign w_stall_inc = TO_EN ? (stall_q + STALL_W'(1)) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      last_d_q    <= 1'b0;
      cnt_q       <= '0;
      stall_q     <= '0;
      gnt_i_q     <= 1'b0;
      gnt_d_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      fill_data_q <= '0;
      fill_idx_q  <= '0;
      fill_we_i_q <= 1'b0;
      fill_we_d_q <= 1'b0;
      done_i_q    <= 1'b0;
      done_d_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      fill_we_i_q <= 1'b0;
      fill_we_d_q <= 1'b0;
      done_i_q    <= 1'b0;
      done_d_q    <= 1'b0;
      err_q       <= 1'b0;
      if (w_timeout) begin
        state_q     <= S_IDLE;
        gnt_i_q     <= 1'b0;
        gnt_d_q     <= 1'b0;
        mem_valid_q <= 1'b0;
        err_q       <= 1'b1;
        cnt_q       <= '0;
        stall_q     <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (REQ_I || REQ_D) begin
              state_q     <= S_ADDR;
              gnt_d_q     <= w_pick_d;
              gnt_i_q     <= !w_pick_d;
              last_d_q    <= w_pick_d;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= (w_pick_d ? ADDR_D : ADDR_I) & LINE_MASK;
              cnt_q       <= '0;
              stall_q     <= '0;
            end
          end
          S_ADDR: begin
            if (MEM_READY) begin
              mem_valid_q <= 1'b0;
              state_q     <= S_FILL;
              stall_q     <= '0;
            end else begin
              stall_q <= w_stall_inc;
            end
          end
          S_FILL: begin
            if (w_accept) begin
              fill_data_q <= MEM_DATA;
              fill_idx_q  <= cnt_q;
              fill_we_i_q <= gnt_i_q;
              fill_we_d_q <= gnt_d_q;
              stall_q     <= '0;
              if (cnt_q == LAST_IDX) begin
                state_q  <= S_DONE;
                done_i_q <= gnt_i_q;
                done_d_q <= gnt_d_q;
                gnt_i_q  <= 1'b0;
                gnt_d_q  <= 1'b0;
                cnt_q    <= '0;
              end else begin
                cnt_q <= cnt_q + 3'd1;
              end
            end else begin
              stall_q <= w_stall_inc;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign GNT_I     = gnt_i_q;
  assign GNT_D     = gnt_d_q;
  assign MEM_VALID = mem_valid_q;
  assign MEM_ADDR  = mem_addr_q;
  assign FILL_DATA = fill_data_q;
  assign FILL_IDX  = fill_idx_q;
  assign FILL_WE_I = fill_we_i_q;
  assign FILL_WE_D = fill_we_d_q;
  assign DONE_I    = done_i_q;
  assign DONE_D    = done_d_q;
  assign ERR       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Exercises the ARB_TIMEOUT_EN watchdog when that macro is defined.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ_I, REQ_D;
  logic [31:0] ADDR_I, ADDR_D;
  logic        GNT_I, GNT_D;
  logic        MEM_VALID;
  logic [31:0] MEM_ADDR;
  logic        MEM_READY;
  logic [31:0] MEM_DATA;
  logic        MEM_WORD_VALID;
  logic [2:0]  MEM_WORD_IDX;
  logic [31:0] FILL_DATA;
  logic [2:0]  FILL_IDX;
  logic        FILL_WE_I, FILL_WE_D, DONE_I, DONE_D, ERR;

  int n_pass  = 0;
  int n_total = 0;

  mem_port_arbiter #(
    .WORDS_PER_LINE (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .REQ_I          (REQ_I),
    .ADDR_I         (ADDR_I),
    .REQ_D          (REQ_D),
    .ADDR_D         (ADDR_D),
    .GNT_I          (GNT_I),
    .GNT_D          (GNT_D),
    .MEM_VALID      (MEM_VALID),
    .MEM_ADDR       (MEM_ADDR),
    .MEM_READY      (MEM_READY),
    .MEM_DATA       (MEM_DATA),
    .MEM_WORD_VALID (MEM_WORD_VALID),
    .MEM_WORD_IDX   (MEM_WORD_IDX),
    .FILL_DATA      (FILL_DATA),
    .FILL_IDX       (FILL_IDX),
    .FILL_WE_I      (FILL_WE_I),
    .FILL_WE_D      (FILL_WE_D),
    .DONE_I         (DONE_I),
    .DONE_D         (DONE_D),
    .ERR            (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic any_out();
    return |{GNT_I, GNT_D, MEM_VALID, MEM_ADDR, FILL_DATA, FILL_IDX,
             FILL_WE_I, FILL_WE_D, DONE_I, DONE_D, ERR};
  endfunction

  // Drives words 0..7 in order; optionally slips a stray index-5 word before word 2.
  task automatic fill_words(input logic side_d, input logic [31:0] seed, input bit glitch);
    for (int i = 0; i < 8; i++) begin
      if (glitch && i == 2) begin
        MEM_WORD_VALID = 1'b1;
        MEM_WORD_IDX   = 3'd5;
        MEM_DATA       = 32'hDEAD_BEEF;
        step();
        chk1("stray_word_ignored", FILL_WE_I | FILL_WE_D, 1'b0);
      end
      MEM_WORD_VALID = 1'b1;
      MEM_WORD_IDX   = 3'(i);
      MEM_DATA       = seed + 32'(i);
      step();
      chk1("fill_we_d", FILL_WE_D, side_d);
      chk1("fill_we_i", FILL_WE_I, !side_d);
      chk32("fill_idx", 32'(FILL_IDX), 32'(i));
      chk32("fill_data", FILL_DATA, seed + 32'(i));
      chk1("done_own", side_d ? DONE_D : DONE_I, i == 7);
      chk1("done_other", side_d ? DONE_I : DONE_D, 1'b0);
      chk1("gnt_own", side_d ? GNT_D : GNT_I, i != 7);
    end
    MEM_WORD_VALID = 1'b0;
  endtask

  // Called with the FSM in IDLE and the requests already applied.
  task automatic run_txn(input logic side_d, input logic [31:0] exp_addr,
                         input logic [31:0] seed, input int ready_delay,
                         input bit glitch, input bit drop_req);
    MEM_READY = 1'b0;
    step();
    chk1("gnt_d", GNT_D, side_d);
    chk1("gnt_i", GNT_I, !side_d);
    chk1("mem_valid_set", MEM_VALID, 1'b1);
    chk32("mem_addr", MEM_ADDR, exp_addr);
    if (drop_req) begin
      REQ_I = 1'b0;
      REQ_D = 1'b0;
    end
    for (int k = 0; k < ready_delay; k++) begin
      step();
      chk1("mem_valid_hold", MEM_VALID, 1'b1);
      chk1("err_quiet", ERR, 1'b0);
    end
    MEM_READY = 1'b1;
    step();
    MEM_READY = 1'b0;
    chk1("mem_valid_drop", MEM_VALID, 1'b0);
    chk32("mem_addr_hold", MEM_ADDR, exp_addr);
    fill_words(side_d, seed, glitch);
    step();
    chk1("idle_gap_gnt", GNT_I | GNT_D, 1'b0);
    chk1("done_single", DONE_I | DONE_D, 1'b0);
  endtask

  initial begin
    RST_N = 1'b0;
    REQ_I = 1'b0; REQ_D = 1'b0;
    ADDR_I = '0; ADDR_D = '0;
    MEM_READY = 1'b0; MEM_DATA = '0;
    MEM_WORD_VALID = 1'b0; MEM_WORD_IDX = '0;
    repeat (2) step();
    chk1("reset_outputs", any_out(), 1'b0);
    RST_N = 1'b1;
    step();
    chk1("idle_outputs", any_out(), 1'b0);

    // Single L1D fill; request withdrawn right after the grant.
    REQ_D = 1'b1; ADDR_D = 32'h0000_1234;
    run_txn(1'b1, 32'h0000_1230, 32'hA000_0000, 0, 1'b0, 1'b1);

    // Fresh pointer: tie goes D, I, D, I.
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    REQ_I = 1'b1; ADDR_I = 32'h2000_0004;
    REQ_D = 1'b1; ADDR_D = 32'h3000_001C;
    run_txn(1'b1, 32'h3000_0018, 32'h1100_0000, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h2000_0000, 32'h2200_0000, 0, 1'b0, 1'b0);
    run_txn(1'b1, 32'h3000_0018, 32'h3300_0000, 0, 1'b0, 1'b0);
    run_txn(1'b0, 32'h2000_0000, 32'h4400_0000, 0, 1'b0, 1'b1);

    // Out-of-order stray word plus a short address stall.
    REQ_I = 1'b1; ADDR_I = 32'h0000_00FF;
    run_txn(1'b0, 32'h0000_00F8, 32'h5500_0000, 10, 1'b1, 1'b1);

    // Reset in the middle of an L1I fill.
    REQ_I = 1'b1; ADDR_I = 32'h0000_4567;
    step();
    chk1("mid_gnt_i", GNT_I, 1'b1);
    chk32("mid_mem_addr", MEM_ADDR, 32'h0000_4560);
    REQ_I = 1'b0;
    MEM_READY = 1'b1;
    step();
    MEM_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MEM_WORD_VALID = 1'b1; MEM_WORD_IDX = 3'(i); MEM_DATA = 32'h6600_0000 + 32'(i);
      step();
      chk1("mid_fill_we_i", FILL_WE_I, 1'b1);
    end
    MEM_WORD_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    chk1("async_reset_outputs", any_out(), 1'b0);
    step();
    chk1("no_done_after_reset", DONE_I, 1'b0);
    chk1("held_reset_outputs", any_out(), 1'b0);
    RST_N = 1'b1;
    REQ_D = 1'b1; ADDR_D = 32'h0000_0ABC;
    run_txn(1'b1, 32'h0000_0AB8, 32'h7700_0000, 0, 1'b0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    // Address phase stalls forever; watchdog fires on the 16th stalled edge.
    REQ_I = 1'b1; ADDR_I = 32'h0000_8000;
    MEM_READY = 1'b0;
    step();
    chk1("to_gnt_i", GNT_I, 1'b1);
    REQ_I = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      chk1("to_err_early", ERR, 1'b0);
    end
    step();
    chk1("to_err_pulse", ERR, 1'b1);
    chk1("to_gnt_drop", GNT_I | GNT_D, 1'b0);
    chk1("to_valid_drop", MEM_VALID, 1'b0);
    chk1("to_no_done", DONE_I | DONE_D, 1'b0);
    step();
    chk1("to_err_single", ERR, 1'b0);
    REQ_I = 1'b1; REQ_D = 1'b1;
    step();
    chk1("to_ptr_kept", GNT_D, 1'b1);
    REQ_I = 1'b0; REQ_D = 1'b0;
`else
    // Without the watchdog a long stall just waits and then completes.
    REQ_D = 1'b1; ADDR_D = 32'h0000_9007;
    run_txn(1'b1, 32'h0000_9000, 32'h8800_0000, 40, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
